// File: rtl/output_accum_bank.sv
// output_accum_bank: NUM_CH BRAM channels of ACC_W signed partial sums with zero/bias fill,
// a 3-stage forwarded read-modify-write accumulator and a shifted/ReLU/saturated drain stream.
// Accumulate: 2-cycle beat-to-write, no stall. Drain: 1-cycle read into a 2-entry skid buffer.
module output_accum_bank #(
   parameter int DW         = 16,
   parameter int ACC_W      = 24,
   parameter int NUM_CH     = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_start,
   input  logic [1:0]               cmd_op,
   input  logic [ADDR_WIDTH:0]      cmd_len,
   input  logic [4:0]               cfg_shift,
   input  logic                     cfg_relu,
   input  logic                     cfg_clear,
   input  logic [NUM_CH*DW-1:0]     bias_data,
   input  logic                     acc_valid,
   input  logic [ADDR_WIDTH-1:0]    acc_addr,
   input  logic [NUM_CH-1:0]        acc_mask,
   input  logic [NUM_CH*DW-1:0]     acc_data,
   input  logic                     acc_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DW-1:0]     out_data,
   output logic [ADDR_WIDTH-1:0]    out_addr,
   output logic                     busy,
   output logic                     done,
   output logic                     sat_flag
);
   localparam int LW = ADDR_WIDTH + 1;
   localparam logic [1:0] OP_ZERO = 2'd0, OP_BIAS = 2'd1, OP_ACCUM = 2'd2;
   localparam logic [LW-1:0] ONE = LW'(1);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] DMAX = ACC_W'(2**(DW-1) - 1);
   localparam logic signed [ACC_W-1:0] DMIN = ACC_W'(-(2**(DW-1)));

   typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_ACC, ST_ACC_WAIT, ST_DRAIN} state_t;
   state_t state, state_nx;

   logic [1:0]                op_q;
   logic [LW-1:0]             len_q, len_m1, cnt, ocnt;
   logic [4:0]                shift_q;
   logic                      relu_q, clear_q;
   logic                      start_ok, acc_take, fin;

   logic [ACC_W-1:0]          mem [NUM_CH][DEPTH];
   logic [NUM_CH*ACC_W-1:0]   rd_q;
   logic                      rd_en;
   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic                      wr_en;
   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [NUM_CH-1:0]         wr_mask;
   logic [NUM_CH*ACC_W-1:0]   wr_dat;

   logic                      s1_vld, s2_vld, h_vld;
   logic [ADDR_WIDTH-1:0]     s1_addr, s2_addr, h_addr;
   logic [NUM_CH-1:0]         s1_mask, s2_mask, h_mask;
   logic [NUM_CH*DW-1:0]      s1_dat;
   logic [NUM_CH*ACC_W-1:0]   s1_sum, s2_sum, h_sum, bias_ext;
   logic [NUM_CH-1:0]         acc_sat, drn_sat;
   logic [NUM_CH*DW-1:0]      drn_dat;

   logic                      drn_issue, rd_pend, push, pop;
   logic [ADDR_WIDTH-1:0]     rd_pend_addr;
   logic [1:0]                occ;
   logic [NUM_CH*DW-1:0]      e1_dat;
   logic [ADDR_WIDTH-1:0]     e1_addr;

   assign start_ok = cmd_start && (state == ST_IDLE);
   assign acc_take = acc_valid && (state == ST_ACC);
   assign len_m1   = len_q - ONE;

   // Per-channel datapath: forwarded saturating add, bias extension, drain shaping
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic signed [ACC_W-1:0] rdv, opnd, shv, rlv;
      logic signed [ACC_W:0]   wsum;
      logic signed [DW-1:0]    part;
      logic                    ovf, hi, lo;

      assign rdv  = $signed(rd_q[g*ACC_W +: ACC_W]);
      assign part = $signed(s1_dat[g*DW +: DW]);
      // newest in-flight result wins; the holding stage covers the read that raced its write
      assign opnd = (s2_vld && s2_addr == s1_addr && s2_mask[g]) ? $signed(s2_sum[g*ACC_W +: ACC_W]) :
                    (h_vld  && h_addr  == s1_addr && h_mask[g])  ? $signed(h_sum[g*ACC_W +: ACC_W])  : rdv;
      assign wsum = (ACC_W+1)'(opnd) + (ACC_W+1)'(part);
      assign ovf  = wsum[ACC_W] ^ wsum[ACC_W-1];
      assign s1_sum[g*ACC_W +: ACC_W] = ovf ? (wsum[ACC_W] ? AMIN : AMAX) : wsum[ACC_W-1:0];
      assign acc_sat[g] = s1_vld && s1_mask[g] && ovf;

      assign bias_ext[g*ACC_W +: ACC_W] = ACC_W'($signed(bias_data[g*DW +: DW]));

      assign shv = rdv >>> shift_q;
      assign rlv = (relu_q && shv < 0) ? '0 : shv;
      assign hi  = rlv > DMAX;
      assign lo  = rlv < DMIN;
      assign drn_dat[g*DW +: DW] = hi ? DMAX[DW-1:0] : (lo ? DMIN[DW-1:0] : rlv[DW-1:0]);
      assign drn_sat[g] = hi || lo;
   end

   // BRAM: one synchronous read port and one per-channel-masked write port
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr_en && wr_mask[c]) mem[c][wr_addr] <= wr_dat[c*ACC_W +: ACC_W];
         if (rd_en) rd_q[c*ACC_W +: ACC_W] <= mem[c][rd_addr];
      end
   end

   // Write-port owner: fill sweep, drain clear-behind, or accumulate retire
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_mask = '0;
      wr_dat  = '0;
      if (state == ST_FILL) begin
         wr_en   = 1'b1;
         wr_addr = cnt[ADDR_WIDTH-1:0];
         wr_mask = '1;
         wr_dat  = (op_q == OP_BIAS) ? bias_ext : '0;
      end else if (state == ST_DRAIN) begin
         wr_en   = rd_pend && clear_q;
         wr_addr = rd_pend_addr;
         wr_mask = '1;
      end else if (s2_vld) begin
         wr_en   = 1'b1;
         wr_addr = s2_addr;
         wr_mask = s2_mask;
         wr_dat  = s2_sum;
      end
   end

   // Drain reads only while the skid buffer has room for everything in flight
   assign pop       = out_valid && out_ready;
   assign push      = rd_pend;
   assign out_valid = (occ != 2'd0);
   assign drn_issue = (state == ST_DRAIN) && (cnt < len_q) &&
                      (({1'b0, occ} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop}));
   assign rd_en     = acc_take || drn_issue;
   assign rd_addr   = (state == ST_DRAIN) ? cnt[ADDR_WIDTH-1:0] : acc_addr;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // FSM next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (cmd_start) begin
            case (cmd_op)
               OP_ZERO, OP_BIAS: state_nx = ST_FILL;
               OP_ACCUM:         state_nx = ST_ACC;
               default:          state_nx = ST_DRAIN;
            endcase
         end
         ST_FILL:     if (cnt == len_m1) state_nx = ST_IDLE;
         ST_ACC:      if (acc_take && acc_last) state_nx = ST_ACC_WAIT;
         ST_ACC_WAIT: if (!s1_vld && !s2_vld) state_nx = ST_IDLE;
         ST_DRAIN:    if (pop && ocnt == len_m1) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   // FSM outputs: busy outside IDLE, fin on the cycle an op completes
   always_comb begin
      busy = (state != ST_IDLE);
      fin  = busy && (state_nx == ST_IDLE);
   end

   // Op context capture, address/handshake counters, done pulse and sticky saturation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         len_q    <= '0;
         shift_q  <= '0;
         relu_q   <= 1'b0;
         clear_q  <= 1'b0;
         cnt      <= '0;
         ocnt     <= '0;
         done     <= 1'b0;
         sat_flag <= 1'b0;
      end else begin
         done <= fin;
         if (start_ok) begin
            op_q     <= cmd_op;
            len_q    <= (cmd_len == '0) ? DEPTH_L : cmd_len;
            shift_q  <= cfg_shift;
            relu_q   <= cfg_relu;
            clear_q  <= cfg_clear;
            cnt      <= '0;
            ocnt     <= '0;
            sat_flag <= 1'b0;
         end else begin
            if (state == ST_FILL || drn_issue) cnt <= cnt + ONE;
            if (pop) ocnt <= ocnt + ONE;
            if ((|acc_sat) || (push && (|drn_sat))) sat_flag <= 1'b1;
         end
      end
   end

   // Accumulate pipeline: S1 operand/add stage, S2 write stage, holding stage after write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         h_vld   <= 1'b0;
         s1_addr <= '0;
         s1_mask <= '0;
         s1_dat  <= '0;
         s2_addr <= '0;
         s2_mask <= '0;
         s2_sum  <= '0;
         h_addr  <= '0;
         h_mask  <= '0;
         h_sum   <= '0;
      end else begin
         s1_vld <= acc_take;
         s2_vld <= s1_vld;
         h_vld  <= s2_vld;
         if (acc_take) begin
            s1_addr <= acc_addr;
            s1_mask <= acc_mask;
            s1_dat  <= acc_data;
         end
         if (s1_vld) begin
            s2_addr <= s1_addr;
            s2_mask <= s1_mask;
            s2_sum  <= s1_sum;
         end
         h_addr <= s2_addr;
         h_mask <= s2_mask;
         h_sum  <= s2_sum;
      end
   end

   // Drain read tracking and 2-entry skid buffer; the head entry drives the output port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend      <= 1'b0;
         rd_pend_addr <= '0;
         occ          <= '0;
         out_data     <= '0;
         out_addr     <= '0;
         e1_dat       <= '0;
         e1_addr      <= '0;
      end else begin
         rd_pend <= drn_issue;
         if (drn_issue) rd_pend_addr <= cnt[ADDR_WIDTH-1:0];
         occ <= occ + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            if (occ == 2'd2) begin
               out_data <= e1_dat;
               out_addr <= e1_addr;
               if (push) begin
                  e1_dat  <= drn_dat;
                  e1_addr <= rd_pend_addr;
               end
            end else if (push) begin
               out_data <= drn_dat;
               out_addr <= rd_pend_addr;
            end
         end else if (push) begin
            if (occ == 2'd0) begin
               out_data <= drn_dat;
               out_addr <= rd_pend_addr;
            end else begin
               e1_dat  <= drn_dat;
               e1_addr <= rd_pend_addr;
            end
         end
      end
   end
endmodule
